// File: rtl/alu_op_sequencer.sv
// Sequential front end for the combinational 32-bit alu: buffers commands in a FIFO,
// drives the alu from registered operands, and returns results with backpressure.
module alu_op_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [2:0]         in_op,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_op,
  input  logic [31:0]        alu_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_c,
  output logic [2:0]         out_op,
  output logic [PTR_W:0]     fifo_count,
  output logic [15:0]        done_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t           state, state_nxt;
  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push_c, pop_c, hs_c;

  assign head = mem[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, pop and handshake decode
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    hs_c      = 1'b0;
    push_c    = in_valid && in_ready;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop_c     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          hs_c = 1'b1;
          if (fifo_count != '0) begin
            pop_c     = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    count_nxt = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // FIFO storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
  end

  // Pointers, counters, alu drive and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      out_valid  <= 1'b0;
      out_c      <= '0;
      out_op     <= '0;
      done_count <= '0;
    end else begin
      fifo_count <= count_nxt;
      // Ready is derived from the registered next count, so no same-cycle ready-through
      in_ready   <= (count_nxt < CNT_W'(DEPTH));
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        alu_a  <= head.a;
        alu_b  <= head.b;
        alu_op <= head.op;
      end
      if (state == ISSUE) begin
        out_c     <= alu_c;
        out_op    <= alu_op;
        out_valid <= 1'b1;
      end
      // A consumed result never lingers into the following ISSUE cycle
      if (hs_c) begin
        out_valid  <= 1'b0;
        done_count <= done_count + 16'd1;
      end
    end
  end

endmodule
